// File: rtl/jump_control_block.sv
// jump_control_block
// Branch/interrupt resolution for the fetch stage of a 16-bit MIPS-style core.
// Decodes the execute-stage opcode with the ALU flags and decides whether the
// PC takes the sequential address or a redirect target. It takes interrupts by
// saving the return address and flags, and it services RET.
//
// Ports:
//   clk             system clock, rising-edge active
//   reset           asynchronous active-low reset (0 = reset)
//   jmp_address_pm  jump target field from program memory
//   current_address current PC, saved as the return address on interrupt
//   op              opcode of the instruction in execute
//   flag_ex         ALU flags: [1] = Z, [0] = C
//   interrupt       level interrupt request, edge-detected here
//   jmp_loc         redirect target address
//   pc_mux_sel      1 = PC loads jmp_loc, 0 = sequential
module jump_control_block #(
  parameter logic [15:0] INT_VECTOR = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] jmp_address_pm,
  input  logic [15:0] current_address,
  input  logic [5:0]  op,
  input  logic [1:0]  flag_ex,
  input  logic        interrupt,
  output logic [15:0] jmp_loc,
  output logic        pc_mux_sel
);

  localparam logic [5:0] OP_JMP = 6'h18;
  localparam logic [5:0] OP_RET = 6'h10;
  localparam logic [5:0] OP_JC  = 6'h1C;
  localparam logic [5:0] OP_JNC = 6'h1D;
  localparam logic [5:0] OP_JZ  = 6'h1E;
  localparam logic [5:0] OP_JNZ = 6'h1F;

  logic        int_d;
  logic [15:0] ret_addr;
  logic [1:0]  ret_flags;
  logic        ret_d;

  logic        int_pulse;
  logic        ret_exec;
  logic [1:0]  eff_flags;
  logic        sel_c;
  logic [15:0] loc_c;

  // Only the first cycle of a high interrupt level vectors.
  assign int_pulse = interrupt & ~int_d;
  // A RET that coincides with an interrupt pulse is dropped, so it must not
  // arm the flag restore either.
  assign ret_exec  = (op == OP_RET) & ~int_pulse;
  // The first instruction after a return sees the interrupted code's flags.
  assign eff_flags = ret_d ? ret_flags : flag_ex;

  always_comb begin
    sel_c = 1'b0;
    loc_c = jmp_address_pm;
    if (int_pulse) begin
      sel_c = 1'b1;
      loc_c = INT_VECTOR;
    end else begin
      unique case (op)
        OP_JMP:  sel_c = 1'b1;
        OP_RET: begin
          sel_c = 1'b1;
          loc_c = ret_addr;
        end
        OP_JC:   sel_c = eff_flags[0];
        OP_JNC:  sel_c = ~eff_flags[0];
        OP_JZ:   sel_c = eff_flags[1];
        OP_JNZ:  sel_c = ~eff_flags[1];
        default: sel_c = 1'b0;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, independent of inputs.
  assign pc_mux_sel = reset ? sel_c : 1'b0;
  assign jmp_loc    = reset ? loc_c : 16'h0000;

  // State register boundary: edge detector, return context, restore marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_d     <= 1'b0;
      ret_addr  <= 16'h0000;
      ret_flags <= 2'b00;
      ret_d     <= 1'b0;
    end else begin
      int_d <= interrupt;
      ret_d <= ret_exec;
      if (int_pulse) begin
        ret_addr  <= current_address;
        ret_flags <= flag_ex;
      end
    end
  end

endmodule

// File: tb/tb_jump_control_block.sv
module tb_jump_control_block;

  logic        clk;
  logic        reset;
  logic [15:0] jmp_address_pm;
  logic [15:0] current_address;
  logic [5:0]  op;
  logic [1:0]  flag_ex;
  logic        interrupt;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;

  int checks;
  int errors;

  jump_control_block #(.INT_VECTOR(16'hF000)) dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_address_pm  (jmp_address_pm),
    .current_address (current_address),
    .op              (op),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs for one cycle and let them settle before checking.
  task automatic drive(input logic [5:0] o, input logic [1:0] f, input logic irq,
                       input logic [15:0] ja, input logic [15:0] ca);
    op = o; flag_ex = f; interrupt = irq; jmp_address_pm = ja; current_address = ca;
    #3;
  endtask

  task automatic expect_out(input string tag, input logic sel, input logic [15:0] loc);
    check_val({tag, "_sel"}, {31'd0, pc_mux_sel}, {31'd0, sel});
    check_val({tag, "_loc"}, {16'd0, jmp_loc}, {16'd0, loc});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    drive(6'h18, 2'b00, 1'b1, 16'h1234, 16'h0000);
    repeat (2) next_cyc();
    #3;
    expect_out("reset_hold", 1'b0, 16'h0000);

    // Release reset with interrupt already high; also JMP present (interrupt wins).
    next_cyc();
    reset = 1'b1;
    drive(6'h18, 2'b11, 1'b1, 16'h1234, 16'h0001);
    expect_out("int_after_reset", 1'b1, 16'hF000);

    // Interrupt held high: no retrigger.
    next_cyc();
    drive(6'h00, 2'b00, 1'b1, 16'h00AA, 16'h0002);
    expect_out("int_held", 1'b0, 16'h00AA);
    next_cyc();
    drive(6'h00, 2'b00, 1'b0, 16'h00BB, 16'h0003);
    expect_out("nonbranch", 1'b0, 16'h00BB);

    next_cyc();
    drive(6'h18, 2'b00, 1'b0, 16'h0008, 16'h0004);
    expect_out("jmp", 1'b1, 16'h0008);

    next_cyc();
    drive(6'h1E, 2'b00, 1'b0, 16'h0020, 16'h0005);
    expect_out("jz_00", 1'b0, 16'h0020);
    next_cyc();
    drive(6'h1F, 2'b00, 1'b0, 16'h0021, 16'h0006);
    expect_out("jnz_00", 1'b1, 16'h0021);
    next_cyc();
    drive(6'h1C, 2'b00, 1'b0, 16'h0022, 16'h0007);
    expect_out("jc_00", 1'b0, 16'h0022);
    next_cyc();
    drive(6'h1D, 2'b00, 1'b0, 16'h0023, 16'h0008);
    expect_out("jnc_00", 1'b1, 16'h0023);
    next_cyc();
    drive(6'h1E, 2'b11, 1'b0, 16'h0024, 16'h0009);
    expect_out("jz_11", 1'b1, 16'h0024);
    next_cyc();
    drive(6'h1C, 2'b11, 1'b0, 16'h0025, 16'h000A);
    expect_out("jc_11", 1'b1, 16'h0025);
    next_cyc();
    drive(6'h1D, 2'b11, 1'b0, 16'h0026, 16'h000B);
    expect_out("jnc_11", 1'b0, 16'h0026);

    // RET returns to saved 0x0001; next instruction uses saved flags 2'b11.
    next_cyc();
    drive(6'h10, 2'b00, 1'b0, 16'h0030, 16'h000C);
    expect_out("ret", 1'b1, 16'h0001);
    next_cyc();
    drive(6'h1E, 2'b00, 1'b0, 16'h0031, 16'h0002);
    expect_out("jz_after_ret", 1'b1, 16'h0031);
    next_cyc();
    drive(6'h1E, 2'b00, 1'b0, 16'h0032, 16'h0003);
    expect_out("jz_ret_cleared", 1'b0, 16'h0032);

    // Second interrupt coincides with RET: interrupt wins, ret_d stays clear.
    next_cyc();
    drive(6'h10, 2'b00, 1'b1, 16'h0040, 16'h0055);
    expect_out("int_with_ret", 1'b1, 16'hF000);
    next_cyc();
    drive(6'h1E, 2'b11, 1'b1, 16'h0041, 16'h0056);
    expect_out("no_ret_d_after_int", 1'b1, 16'h0041);
    next_cyc();
    drive(6'h10, 2'b11, 1'b0, 16'h0042, 16'h0057);
    expect_out("ret_overwritten", 1'b1, 16'h0055);
    next_cyc();
    drive(6'h1F, 2'b11, 1'b0, 16'h0043, 16'h0058);
    expect_out("jnz_saved_00", 1'b1, 16'h0043);

    // Asynchronous reset mid-cycle forces outputs low at once.
    next_cyc();
    drive(6'h18, 2'b00, 1'b0, 16'h0099, 16'h0059);
    expect_out("jmp_pre_reset", 1'b1, 16'h0099);
    reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 16'h0000);
    next_cyc();
    reset = 1'b1;
    drive(6'h10, 2'b00, 1'b0, 16'h00A0, 16'h005A);
    expect_out("ret_after_reset", 1'b1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
